// File: rtl/ser_add_pkg.sv
// ser_add_pkg: shared state encoding and default width for the serial adder
// Exports: state_e (IDLE/RUN/DONE), SER_ADD_WIDTH
package ser_add_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
  localparam int SER_ADD_WIDTH = 8;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
// Ports: x, y, ci in; s = sum bit, co = carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one result bit per RUN cycle
// Ports: clk, rst_n (sync, active-low); start/a/b/cin captured in IDLE;
//        busy in RUN/DONE, done one-cycle pulse, sum/cout registered result
module serial_adder
  import ser_add_pkg::*;
#(
  parameter int WIDTH = SER_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             s, co;
  fa_cell u_fa (
    .x (a_q[0]),
    .y (b_q[0]),
    .ci(carry_q),
    .s (s),
    .co(co)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = co;
        res_d   = {s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // last bit: publish the completed result together with the final carry
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = co;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
